// File: rtl/apb_arb_pkg.sv
// Shared types and defaults for the APB requester arbiter.
package apb_arb_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StSetup  = 2'd1,
        StAccess = 2'd2,
        StDone   = 2'd3
    } arb_state_e;

    localparam int unsigned DefaultAddrW = 3;
    localparam int unsigned DefaultDataW = 8;

    // Index width for a requester count, never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin selector: first requester above last_grant wins.
module rr_arbiter
    import apb_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    localparam int unsigned IdxW = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IdxW-1:0]    last_grant,
    input  logic               enable,
    output logic [NUM_REQ-1:0] grant,
    output logic [IdxW-1:0]    grant_idx
);

    logic found;
    int   cand;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = 0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            cand = (int'(last_grant) + 1 + i) % int'(NUM_REQ);
            if (enable && !found && req[cand]) begin
                found     = 1'b1;
                grant_idx = IdxW'(cand);
            end
        end
        if (found) begin
            grant[grant_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/apb_req_arbiter.sv
// Round-robin APB master sequencer sharing one APB bus between NUM_REQ requesters.
// Optional APB_ARB_PREADY_EN adds pready wait states with a TIMEOUT-cycle limit.
module apb_req_arbiter
    import apb_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned ADDR_W  = DefaultAddrW,
    parameter int unsigned DATA_W  = DefaultDataW,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        wr,
    input  logic [NUM_REQ*ADDR_W-1:0] addr,
    input  logic [NUM_REQ*DATA_W-1:0] wdata,
    output logic [NUM_REQ-1:0]        done,
    output logic [DATA_W-1:0]         rdata,
    output logic                      err,
    output logic                      busy,
    output logic                      psel,
    output logic                      penable,
    output logic [ADDR_W-1:0]         paddr,
    output logic                      pwrite,
    output logic [DATA_W-1:0]         pwdata,
    input  logic [DATA_W-1:0]         prdata,
`ifdef APB_ARB_PREADY_EN
    input  logic                      pready,
`endif
    input  logic                      pslverr
);

    localparam int unsigned IdxW = idx_width(NUM_REQ);

    arb_state_e         state_q, state_d;
    logic [IdxW-1:0]    last_grant_q;
    logic [NUM_REQ-1:0] grant;
    logic [IdxW-1:0]    grant_idx;
    logic               grant_any;
    logic               access_end;
    logic               psel_d, penable_d, busy_d;
    logic [NUM_REQ-1:0] done_d;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .req        (req),
        .last_grant (last_grant_q),
        .enable     (state_q == StIdle),
        .grant      (grant),
        .grant_idx  (grant_idx)
    );

    assign grant_any = |grant;

`ifdef APB_ARB_PREADY_EN
    localparam int unsigned CntW = $clog2(TIMEOUT + 1);
    logic [CntW-1:0] wait_q;
    logic            timeout_hit;

    // Fires on the TIMEOUT-th ACCESS cycle that still sees pready low.
    assign timeout_hit = !pready && (wait_q == CntW'(TIMEOUT - 1));
    assign access_end  = pready || timeout_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_q <= '0;
        end else if (state_q == StIdle && grant_any) begin
            wait_q <= '0;
        end else if (state_q == StAccess && !pready) begin
            wait_q <= wait_q + 1'b1;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT != 0);
    assign access_end     = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (grant_any) state_d = StSetup;
            StSetup:  state_d = StAccess;
            StAccess: if (access_end) state_d = StDone;
            StDone:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Outputs are decoded from the next state and registered below.
    always_comb begin
        psel_d    = (state_d == StSetup) || (state_d == StAccess);
        penable_d = (state_d == StAccess);
        busy_d    = (state_d != StIdle);
        done_d    = '0;
        if (state_d == StDone) begin
            done_d[last_grant_q] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= IdxW'(NUM_REQ - 1);
            psel         <= 1'b0;
            penable      <= 1'b0;
            busy         <= 1'b0;
            done         <= '0;
            paddr        <= '0;
            pwrite       <= 1'b0;
            pwdata       <= '0;
            rdata        <= '0;
            err          <= 1'b0;
        end else begin
            psel    <= psel_d;
            penable <= penable_d;
            busy    <= busy_d;
            done    <= done_d;
            if (grant_any) begin
                last_grant_q <= grant_idx;
                paddr        <= addr[int'(grant_idx) * int'(ADDR_W) +: ADDR_W];
                pwrite       <= wr[grant_idx];
                pwdata       <= wdata[int'(grant_idx) * int'(DATA_W) +: DATA_W];
            end
            if (state_q == StAccess) begin
`ifdef APB_ARB_PREADY_EN
                if (pready) begin
                    err <= pslverr;
                    if (!pwrite) rdata <= prdata;
                end else if (timeout_hit) begin
                    err   <= 1'b1;
                    rdata <= '0;
                end
`else
                err <= pslverr;
                if (!pwrite) rdata <= prdata;
`endif
            end
        end
    end

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Scoreboard bench for apb_req_arbiter; exercises the pready path when APB_ARB_PREADY_EN is set.
module tb_apb_req_arbiter;

    localparam int NR = 2;
    localparam int AW = 3;
    localparam int DW = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic [NR-1:0]    req, wr, done;
    logic [NR*AW-1:0] addr;
    logic [NR*DW-1:0] wdata;
    logic [DW-1:0]    rdata, pwdata, prdata;
    logic [AW-1:0]    paddr;
    logic             err, busy, psel, penable, pwrite, pslverr;
`ifdef APB_ARB_PREADY_EN
    logic pready;
    int   acc_cnt = 0;
    int   wait_n  = 0;
`endif

    logic          req_a   [NR];
    logic          wr_a    [NR];
    logic [AW-1:0] addr_a  [NR];
    logic [DW-1:0] wdata_a [NR];

    typedef struct {
        int          who;
        logic [7:0]  rd;
        logic        er;
    } exp_t;

    exp_t       sb[$];
    exp_t       mon_e;
    int         done_cyc[$];
    logic [7:0] model_rd = 8'h00;
    int         cyc = 0;
    int         n_cmp = 0;
    int         n_bad = 0;
    int         c0;

    always #5 clk = ~clk;

    apb_req_arbiter #(
        .NUM_REQ (NR),
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .TIMEOUT (15)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .wr      (wr),
        .addr    (addr),
        .wdata   (wdata),
        .done    (done),
        .rdata   (rdata),
        .err     (err),
        .busy    (busy),
        .psel    (psel),
        .penable (penable),
        .paddr   (paddr),
        .pwrite  (pwrite),
        .pwdata  (pwdata),
        .prdata  (prdata),
`ifdef APB_ARB_PREADY_EN
        .pready  (pready),
`endif
        .pslverr (pslverr)
    );

    always_comb begin
        req   = '0;
        wr    = '0;
        addr  = '0;
        wdata = '0;
        for (int i = 0; i < NR; i++) begin
            req[i]             = req_a[i];
            wr[i]              = wr_a[i];
            addr[i*AW +: AW]   = addr_a[i];
            wdata[i*DW +: DW]  = wdata_a[i];
        end
    end

    // Slave: read data depends on address and is only valid in ACCESS.
    assign prdata  = (psel && penable) ? 8'h30 + 8'({paddr, 1'b0}) : 8'hEE;
    assign pslverr = psel && penable && (paddr == 3'd5);

`ifdef APB_ARB_PREADY_EN
    assign pready = (acc_cnt >= wait_n);
    always @(posedge clk) acc_cnt <= (psel && penable) ? acc_cnt + 1 : 0;
`endif

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic expect_xfer(input int who, input bit w, input logic [2:0] a, input bit tmo);
        exp_t e;
        if (tmo) model_rd = 8'h00;
        else if (!w) model_rd = 8'h30 + {4'b0, a, 1'b0};
        e.who = who;
        e.rd  = model_rd;
        e.er  = tmo || (a == 3'd5);
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (|done) begin
            done_cyc.push_back(cyc);
            if (sb.size() == 0) begin
                check_eq("unexpected_done", 32'(done), 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check_eq("done_who", 32'(done), 32'd1 << mon_e.who);
                check_eq("rdata", 32'(rdata), 32'(mon_e.rd));
                check_eq("err", 32'(err), 32'(mon_e.er));
            end
        end
    end

    // Drives a command and holds it until done; returns #1 into the cycle after done.
    task automatic xfer(input int r, input bit w, input logic [2:0] a, input logic [7:0] d,
                        input bit detail);
        int n;
        req_a[r]   = 1'b1;
        wr_a[r]    = w;
        addr_a[r]  = a;
        wdata_a[r] = d;
        if (detail) begin
            @(negedge clk);
            check_eq("idle_phase", {busy, psel, penable}, 32'd0);
            @(negedge clk);
            check_eq("setup_phase", {busy, psel, penable, pwrite, paddr, pwdata},
                     {1'b1, 1'b1, 1'b0, w, a, d});
            @(negedge clk);
            check_eq("access_phase", {busy, psel, penable, pwrite, paddr, pwdata},
                     {1'b1, 1'b1, 1'b1, w, a, d});
            @(negedge clk);
            check_eq("done_pulse", 32'(done), 32'd1 << r);
            check_eq("done_phase", {psel, penable, pwrite, paddr, pwdata},
                     {1'b0, 1'b0, w, a, d});
        end else begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!done[r] && n < 40);
            check_eq("done_seen", 32'(done[r]), 32'd1);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        for (int i = 0; i < NR; i++) begin
            req_a[i] = 1'b0; wr_a[i] = 1'b0; addr_a[i] = '0; wdata_a[i] = '0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("reset_vals", {psel, penable, busy, done, rdata, err, paddr, pwrite, pwdata},
                 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Single read, then single write leaving rdata untouched.
        expect_xfer(0, 1'b0, 3'd2, 1'b0);
        xfer(0, 1'b0, 3'd2, 8'h00, 1'b1);
        req_a[0] = 1'b0;
        expect_xfer(1, 1'b1, 3'd4, 1'b0);
        xfer(1, 1'b1, 3'd4, 8'h08, 1'b1);
        req_a[1] = 1'b0;

        // Both requesters busy: must alternate 0,1,0,1 at 4-cycle spacing.
        done_cyc.delete();
        expect_xfer(0, 1'b0, 3'd1, 1'b0);
        expect_xfer(1, 1'b1, 3'd6, 1'b0);
        expect_xfer(0, 1'b1, 3'd7, 1'b0);
        expect_xfer(1, 1'b0, 3'd3, 1'b0);
        fork
            begin
                xfer(0, 1'b0, 3'd1, 8'h00, 1'b0);
                xfer(0, 1'b1, 3'd7, 8'hA5, 1'b0);
                req_a[0] = 1'b0;
            end
            begin
                xfer(1, 1'b1, 3'd6, 8'h5A, 1'b0);
                xfer(1, 1'b0, 3'd3, 8'h00, 1'b0);
                req_a[1] = 1'b0;
            end
        join
        check_eq("rr_count", 32'(done_cyc.size()), 32'd4);
        for (int i = 0; i + 1 < done_cyc.size(); i++) begin
            check_eq("rr_gap", 32'(done_cyc[i+1] - done_cyc[i]), 32'd4);
        end

        // Slave error, then a clean read clears err.
        expect_xfer(0, 1'b1, 3'd5, 1'b0);
        xfer(0, 1'b1, 3'd5, 8'h55, 1'b0);
        req_a[0] = 1'b0;
        expect_xfer(1, 1'b0, 3'd3, 1'b0);
        xfer(1, 1'b0, 3'd3, 8'h00, 1'b0);
        req_a[1] = 1'b0;

        // Reset during ACCESS abandons the transfer and restores the pointer.
        req_a[0] = 1'b1; wr_a[0] = 1'b0; addr_a[0] = 3'd2;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check_eq("pre_rst_access", {psel, penable}, 32'd3);
        rst = 1'b1;
        @(negedge clk);
        check_eq("rst_abort", {psel, penable, busy, done, rdata, err}, 32'd0);
        rst = 1'b0;
        model_rd = 8'h00;
        expect_xfer(0, 1'b0, 3'd4, 1'b0);
        expect_xfer(1, 1'b0, 3'd6, 1'b0);
        fork
            begin
                xfer(0, 1'b0, 3'd4, 8'h00, 1'b0);
                req_a[0] = 1'b0;
            end
            begin
                xfer(1, 1'b0, 3'd6, 8'h00, 1'b0);
                req_a[1] = 1'b0;
            end
        join

`ifdef APB_ARB_PREADY_EN
        // Three wait states, then a wait that runs into the timeout.
        wait_n = 3;
        c0 = cyc;
        expect_xfer(0, 1'b0, 3'd1, 1'b0);
        xfer(0, 1'b0, 3'd1, 8'h00, 1'b0);
        req_a[0] = 1'b0;
        check_eq("pready_latency", 32'(done_cyc[done_cyc.size()-1] - c0), 32'd6);
        wait_n = 100;
        expect_xfer(1, 1'b0, 3'd2, 1'b1);
        xfer(1, 1'b0, 3'd2, 8'h00, 1'b0);
        req_a[1] = 1'b0;
        wait_n = 0;
`endif

        repeat (4) @(negedge clk);
        check_eq("sb_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
